wb_arbiter: RTL and testbench

Writeback arbiter and scoreboard on the write side of the register file. It merges single-cycle ALU results and long-latency load/mul-div (LSU) results into the single register-file write port (`reg_write`/`dest`/`write_data`). It tracks registers with outstanding long-latency writes and raises a hazard stall toward decode. LSU starvation is bounded by briefly holding the ALU path.

---
 rtl/wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter and long-latency register scoreboard
module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // single-cycle ALU results
  input  logic            alu_valid,
  input  logic [4:0]      alu_dest,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_hold,
  // long-latency load / mul-div results
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_dest,
  input  logic [XLEN-1:0] lsu_data,
  // issue-side scoreboard updates
  input  logic            issue_valid,
  input  logic            issue_long,
  input  logic [4:0]      issue_dest,
  // decode-side hazard checks
  input  logic [4:0]      chk_src1,
  input  logic [4:0]      chk_src2,
  input  logic [4:0]      chk_dest,
  output logic            stall,
  output logic [31:0]     pending,
  // register-file write port
  output logic            reg_write,
  output logic [4:0]      dest,
  output logic [XLEN-1:0] write_data,
  output logic            waw_err
);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_HOLD   = 1'b1
  } state_t;

  // last wait-counter value before the ALU path gets held
  localparam logic [3:0] WAIT_LAST = 4'(STARVE_MAX - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  wait_q;
  logic [3:0]  wait_d;

  logic        alu_grant;
  logic        lsu_accept;
  logic        lsu_blocked;
  logic        wb_lsu_q;

  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_d;

  logic        waw_issue;
  logic        waw_alu;
  logic        waw_lsu;

  // the hold cycle is a direct decode of the registered FSM state
  assign alu_hold = (state_q == ST_HOLD);

  // grant: hold forces the LSU through, otherwise the ALU has priority
  always_comb begin
    alu_grant = 1'b0;
    lsu_ready = 1'b0;
    if (!rst) begin
      if (alu_hold) begin
        lsu_ready = 1'b1;
      end else if (alu_valid) begin
        alu_grant = 1'b1;
      end else begin
        lsu_ready = 1'b1;
      end
    end
  end

  assign lsu_accept  = lsu_valid && lsu_ready;
  assign lsu_blocked = lsu_valid && !lsu_ready;

  // starvation FSM state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // starvation next-state: count consecutive blocked cycles, hold ALU for one cycle
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_NORMAL: begin
        if (lsu_blocked) begin
          if (wait_q == WAIT_LAST) begin
            state_d = ST_HOLD;
            wait_d  = 4'd0;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end else begin
          wait_d = 4'd0;
        end
      end
      ST_HOLD: begin
        // a single hold cycle whether or not the LSU still has a result
        state_d = ST_NORMAL;
        wait_d  = 4'd0;
      end
      default: begin
        state_d = ST_NORMAL;
        wait_d  = 4'd0;
      end
    endcase
  end

  // write stage: the granted result is registered toward the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write  <= 1'b0;
      dest       <= 5'd0;
      write_data <= '0;
      wb_lsu_q   <= 1'b0;
    end else if (alu_grant) begin
      reg_write  <= (alu_dest != 5'd0);
      dest       <= alu_dest;
      write_data <= alu_data;
      wb_lsu_q   <= 1'b0;
    end else if (lsu_accept) begin
      reg_write  <= (lsu_dest != 5'd0);
      dest       <= lsu_dest;
      write_data <= lsu_data;
      wb_lsu_q   <= 1'b1;
    end else begin
      // address and data hold; only the enable drops
      reg_write  <= 1'b0;
      wb_lsu_q   <= 1'b0;
    end
  end

  // scoreboard update: issue sets, retiring LSU write clears, set wins on collision
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue_valid && issue_long && (issue_dest != 5'd0)) begin
      set_mask[issue_dest] = 1'b1;
    end
    if (reg_write && wb_lsu_q) begin
      clr_mask[dest] = 1'b1;
    end
    pending_d    = (pending & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_d;
    end
  end

  // RAW on either source and WAW on the destination both stall decode
  assign stall = pending[chk_src1] | pending[chk_src2] | pending[chk_dest];

  // protocol checks: double long issue, ALU overtaking a pending write, orphan LSU write
  always_comb begin
    waw_issue = issue_valid && issue_long && (issue_dest != 5'd0) &&
                pending[issue_dest] && !clr_mask[issue_dest];
    waw_alu   = alu_grant && (alu_dest != 5'd0) && pending[alu_dest];
    waw_lsu   = lsu_accept && (lsu_dest != 5'd0) && !pending[lsu_dest];
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      waw_err <= 1'b0;
    end else if (waw_issue || waw_alu || waw_lsu) begin
      waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_hold;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_dest;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic        issue_long;
  logic [4:0]  issue_dest;
  logic [4:0]  chk_src1;
  logic [4:0]  chk_src2;
  logic [4:0]  chk_dest;
  logic        stall;
  logic [31:0] pending;
  logic        reg_write;
  logic [4:0]  dest;
  logic [31:0] write_data;
  logic        waw_err;

  wb_arbiter #(.XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_hold(alu_hold),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_dest(lsu_dest), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_long(issue_long), .issue_dest(issue_dest),
    .chk_src1(chk_src1), .chk_src2(chk_src2), .chk_dest(chk_dest),
    .stall(stall), .pending(pending),
    .reg_write(reg_write), .dest(dest), .write_data(write_data), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] ldata;
    logic        exp_ready;
    logic        exp_rw;
    logic [4:0]  exp_dest;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  d;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[9];
  wr_t  sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    wr_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("reg_write", 32'(reg_write), 32'(e.rw));
      check("dest", 32'(dest), 32'(e.d));
      check("write_data", write_data, e.data);
    end
  endtask

  task automatic set_idle();
    alu_valid   = 1'b0; alu_dest = 5'd0; alu_data = 32'd0;
    lsu_valid   = 1'b0; lsu_dest = 5'd0; lsu_data = 32'd0;
    issue_valid = 1'b0; issue_long = 1'b0; issue_dest = 5'd0;
  endtask

  task automatic drive_cycle(input logic av, input logic [4:0] ad, input logic [31:0] adata,
                             input logic lv, input logic [4:0] ld, input logic [31:0] ldata,
                             input logic iv, input logic [4:0] idest,
                             input logic exp_ready, input logic exp_rw,
                             input logic [4:0] exp_dest, input logic [31:0] exp_data);
    wr_t e;
    @(posedge clk); #1;
    alu_valid   = av; alu_dest = ad; alu_data = adata;
    lsu_valid   = lv; lsu_dest = ld; lsu_data = ldata;
    issue_valid = iv; issue_long = iv; issue_dest = idest;
    @(negedge clk);
    pop_check();
    check("lsu_ready", 32'(lsu_ready), 32'(exp_ready));
    e.rw = exp_rw; e.d = exp_dest; e.data = exp_data;
    sb.push_back(e);
  endtask

  task automatic flush();
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    pop_check();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // table: {alu v,dest,data, lsu v,dest,data, ready, write rw,dest,data}
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h11,       1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  32'h11};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h22, 1'b1, 1'b0, 5'd0,  32'h22};
    vecs[4] = '{1'b1, 5'd12, 32'hA5A5,     1'b1, 5'd0, 32'h33, 1'b0, 1'b1, 5'd12, 32'hA5A5};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h33, 1'b1, 1'b0, 5'd0,  32'h33};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[7] = '{1'b1, 5'd1,  32'h1,        1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 5'd1,  32'h1};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd1,  32'h1};

    chk_src1 = 5'd0; chk_src2 = 5'd0; chk_dest = 5'd0;
    set_idle();
    rst = 1'b1;
    lsu_valid = 1'b1;
    @(negedge clk);
    check("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_dest", 32'(dest), 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_alu_hold", 32'(alu_hold), 32'd0);
    check("rst_waw_err", 32'(waw_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();

    // table-driven grant and write-stage vectors
    for (int i = 0; i < 9; i++) begin
      drive_cycle(vecs[i].av, vecs[i].ad, vecs[i].adata, vecs[i].lv, vecs[i].ld, vecs[i].ldata,
                  1'b0, 5'd0, vecs[i].exp_ready, vecs[i].exp_rw, vecs[i].exp_dest, vecs[i].exp_data);
    end
    flush();
    check("tbl_pending0", pending, 32'd0);
    check("tbl_waw_err", 32'(waw_err), 32'd0);

    // long issue to x7, stall until LSU writeback retires
    do_reset();
    chk_src1 = 5'd7;
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0);
    check("stall_issue_cycle", 32'(stall), 32'd0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("pending7_set", pending, 32'h80);
    check("stall_src1", 32'(stall), 32'd1);
    chk_src1 = 5'd0; chk_src2 = 5'd7; #1;
    check("stall_src2", 32'(stall), 32'd1);
    chk_src2 = 5'd0; chk_dest = 5'd7; #1;
    check("stall_dest", 32'(stall), 32'd1);
    chk_dest = 5'd0; #1;
    check("stall_other", 32'(stall), 32'd0);
    chk_src1 = 5'd7;
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'h1234);
    check("stall_accept", 32'(stall), 32'd1);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 32'h1234);
    check("stall_write", 32'(stall), 32'd1);
    flush();
    check("stall_released", 32'(stall), 32'd0);
    check("pending7_clr", pending, 32'd0);
    check("seqa_waw_err", 32'(waw_err), 32'd0);
    chk_src1 = 5'd0;

    // starvation: continuous ALU traffic, LSU held off at most STARVE_MAX cycles, twice
    do_reset();
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k <= 10; k++) begin
      logic hold_k;
      hold_k = (k == 4) || (k == 9);
      if (k == 4)
        drive_cycle(1'b1, 5'd2, 32'h100 + k, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b1, 1'b1, 5'd4, 32'h44);
      else if (k == 9)
        drive_cycle(1'b1, 5'd2, 32'h100 + k, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h55);
      else
        drive_cycle(1'b1, 5'd2, 32'h100 + k, (k != 10), (k < 4) ? 5'd4 : 5'd0,
                    (k < 4) ? 32'h44 : 32'h55, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 32'h100 + k);
      check($sformatf("alu_hold_k%0d", k), 32'(alu_hold), 32'(hold_k));
    end
    flush();
    check("starve_pending", pending, 32'd0);
    check("starve_waw_err", 32'(waw_err), 32'd0);

    // double long issue to x9 without writeback
    do_reset();
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0);
    check("waw9_before", 32'(waw_err), 32'd0);
    for (int j = 0; j < 3; j++) begin
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0);
      check($sformatf("waw9_sticky%0d", j), 32'(waw_err), 32'd1);
    end
    flush();
    do_reset();
    check("waw9_reset", 32'(waw_err), 32'd0);

    // ALU write to a pending register
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 32'h0);
    drive_cycle(1'b1, 5'd11, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 32'h77);
    flush();
    check("waw_alu", 32'(waw_err), 32'd1);

    // LSU write to a register that was never issued long
    do_reset();
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h88, 1'b0, 5'd0, 1'b1, 1'b1, 5'd13, 32'h88);
    flush();
    check("waw_lsu", 32'(waw_err), 32'd1);

    // reset right after an LSU acceptance kills the in-flight write
    do_reset();
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0);
    drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 1'b1, 5'd3, 32'h33);
    @(posedge clk); #1;
    set_idle();
    rst = 1'b1;
    lsu_valid = 1'b1; lsu_dest = 5'd3; lsu_data = 32'h99;
    @(negedge clk);
    pop_check();
    check("midrst_lsu_ready", 32'(lsu_ready), 32'd0);
    check("midrst_pending3", pending, 32'h8);
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    check("midrst_reg_write", 32'(reg_write), 32'd0);
    check("midrst_dest", 32'(dest), 32'd0);
    check("midrst_write_data", write_data, 32'd0);
    check("midrst_pending", pending, 32'd0);
    check("midrst_alu_hold", 32'(alu_hold), 32'd0);
    check("midrst_waw_err", 32'(waw_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
